// File: rtl/int_muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and default width.
package int_muldiv_pkg;
  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation; used for operand magnitude on entry
// and for the result sign fixup on exit.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] z
);
  assign z = neg ? -x : x;
endmodule

// File: rtl/int_muldiv.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide,
// one bit per cycle, plus a single-edge path for divide-by-zero/overflow.
module int_muldiv
  import int_muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  y,
  output logic [TAG_W-1:0] tag_out
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t             state, state_nxt;
  logic [2:0]         op_q;
  logic               neg_q;
  logic [XLEN-1:0]    opb_q;
  logic [2*XLEN-1:0]  prod_q;
  logic [CW-1:0]      cnt_q;

  logic               accept, fast, a_sgn, b_sgn, res_neg;
  logic [XLEN-1:0]    fast_y, y_fin;
  logic [1:0][XLEN-1:0] ent_x, ent_z;
  logic [1:0]         ent_neg;

  assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready && !flush;

  // Operand conditioning on entry
  always_comb begin
    a_sgn   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_sgn   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    ent_x[0]   = a;
    ent_x[1]   = b;
    ent_neg[0] = a_sgn & a[XLEN-1];
    ent_neg[1] = b_sgn & b[XLEN-1];
    res_neg = (op == OP_REM) ? ent_neg[0] : (ent_neg[0] ^ ent_neg[1]);
  end

  for (genvar i = 0; i < 2; i++) begin : g_ent
    muldiv_sign_fix #(.W(XLEN)) u_fix (.x(ent_x[i]), .neg(ent_neg[i]), .z(ent_z[i]));
  end

  always_comb begin
    fast   = 1'b0;
    fast_y = '0;
    if (op[2]) begin
      if (b == '0) begin
        fast   = 1'b1;
        fast_y = op[1] ? a : '1;
      end else if ((op == OP_DIV || op == OP_REM) && a == SMIN && b == '1) begin
        fast   = 1'b1;
        fast_y = op[1] ? '0 : a;
      end
    end
  end

  // One iteration step of each algorithm
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt;

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opb_q} : '0);
    mul_nxt  = {mul_sum, prod_q[XLEN-1:1]};
    div_sh   = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opb_q};
    div_ge   = ~div_diff[XLEN];
    div_nxt  = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                prod_q[XLEN-2:0], div_ge};
  end

  // Exit fixup: divide results sit in the low half so one wide negator serves both
  logic [2*XLEN-1:0] ext_x, ext_z;
  always_comb begin
    if (op_q[2]) ext_x = {{XLEN{1'b0}}, (op_q[1] ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0])};
    else         ext_x = prod_q;
    y_fin = (op_q == OP_MUL || op_q[2]) ? ext_z[XLEN-1:0] : ext_z[2*XLEN-1:XLEN];
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_exit (.x(ext_x), .neg(neg_q), .z(ext_z));

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE: if (accept) state_nxt = fast ? S_DONE : S_BUSY;
        S_BUSY: if (cnt_q[CW-1]) state_nxt = S_DONE;
        S_DONE: if (out_ready) state_nxt = accept ? (fast ? S_DONE : S_BUSY) : S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Counter runs XLEN-1..0 over the steps; wrapping negative marks the fixup edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0; neg_q <= 1'b0; opb_q <= '0; prod_q <= '0;
      cnt_q <= '0; y <= '0; tag_out <= '0;
    end else if (accept) begin
      op_q    <= op;
      neg_q   <= res_neg;
      tag_out <= tag_in;
      cnt_q   <= CW'(XLEN - 1);
      opb_q   <= op[2] ? ent_z[1] : ent_z[0];
      prod_q  <= {{XLEN{1'b0}}, (op[2] ? ent_z[0] : ent_z[1])};
      if (fast) y <= fast_y;
    end else if (state == S_BUSY && !flush) begin
      if (!cnt_q[CW-1]) begin
        prod_q <= op_q[2] ? div_nxt : mul_nxt;
        cnt_q  <= cnt_q - CW'(1);
      end else begin
        y <= y_fin;
      end
    end
  end
endmodule

// File: tb/tb_int_muldiv.sv
// Self-checking bench for int_muldiv: directed RV32M cases, random ops against
// an arithmetic reference, backpressure, flush and async reset.
module tb_int_muldiv;
  localparam int XLEN = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [2:0] op = '0;
  logic [XLEN-1:0] a = '0, b = '0, y;
  logic [TAG_W-1:0] tag_in = '0, tag_out;

  int checks = 0, errors = 0;

  int_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .tag_in(tag_in), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .tag_out(tag_out));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_y(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int sx, sz;
    logic [31:0] r;
    sa = longint'($signed(x)); sb = longint'($signed(z));
    ua = longint'({32'b0, x}); ub = longint'({32'b0, z});
    sx = $signed(x); sz = $signed(z);
    r = '0;
    case (o)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: r = (z == 0) ? 32'hFFFF_FFFF : (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) ? x : 32'(sx / sz);
      3'd5: r = (z == 0) ? 32'hFFFF_FFFF : x / z;
      3'd6: r = (z == 0) ? x : (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) ? 32'h0 : 32'(sx % sz);
      default: r = (z == 0) ? x : x % z;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z);
    return o[2] && (z == 0 || ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && z == 32'hFFFF_FFFF));
  endfunction

  // Present an op for one edge (caller sits #1 after a posedge with the unit ready)
  task automatic start(input logic [2:0] o, input logic [31:0] x, input logic [31:0] z, input logic [4:0] t);
    op = o; a = x; b = z; tag_in = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges after the accept edge until out_valid; -1 on timeout
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = -1;
  endtask

  task automatic pop();
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (y !== '0) begin errors++; $display("FAIL reset_y got %h exp 0", y); end
    checks++; if (tag_out !== '0) begin errors++; $display("FAIL reset_tag got %h exp 0", tag_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int lat;
    start(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd17);
    wait_out(lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", lat); end
    checks++; if (y !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_y got %h exp ffffffeb", y); end
    checks++; if (tag_out !== 5'd17) begin errors++; $display("FAIL mul_tag got %0d exp 17", tag_out); end
    pop();
  endtask

  task automatic test_directed();
    logic [2:0] ops [11] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6, 3'd7};
    logic [31:0] as [11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd40};
    logic [31:0] bs [11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7, 32'd0, 32'd0,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd6};
    logic [31:0] ex [11] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'd14, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'd4};
    int el [11] = '{33, 33, 33, 33, 33, 33, 0, 0, 0, 0, 33};
    int lat;
    for (int i = 0; i < 11; i++) begin
      start(ops[i], as[i], bs[i], 5'(i + 1));
      wait_out(lat);
      checks++; if (lat != el[i]) begin errors++; $display("FAIL dir%0d_latency got %0d exp %0d", i, lat, el[i]); end
      checks++; if (y !== ex[i]) begin errors++; $display("FAIL dir%0d_y got %h exp %h", i, y, ex[i]); end
      pop();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] e1, e2;
    e1 = ref_y(3'd1, 32'h1234_5678, 32'hF000_0001);
    e2 = ref_y(3'd5, 32'hDEAD_BEEF, 32'd13);
    start(3'd1, 32'h1234_5678, 32'hF000_0001, 5'd3);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      checks++; if (y !== e1 || tag_out !== 5'd3 || out_valid !== 1'b1)
        begin errors++; $display("FAIL hold%0d_y got %h/%0d exp %h/3", i, y, tag_out, e1); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready got %b exp 0", i, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; b = 32'd13; tag_in = 5'd4;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL b2b_accept got valid %b ready %b exp 0 0", out_valid, in_ready); end
    wait_out(lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_latency got %0d exp 33", lat); end
    checks++; if (y !== e2 || tag_out !== 5'd4) begin errors++; $display("FAIL b2b_y got %h/%0d exp %h/4", y, tag_out, e2); end
    pop();
  endtask

  task automatic test_flush();
    bit seen;
    start(3'd4, 32'd1000, 32'd3, 5'd9);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_busy got valid %b ready %b exp 0 1", out_valid, in_ready); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL flush_busy_result got 1 exp 0"); end
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4; tag_in = 5'd2;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_accept got ready %b exp 1", in_ready); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL flush_accept_result got 1 exp 0"); end
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [31:0] x, z, e;
    int lat, el;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7)); x = $urandom; z = $urandom;
      if (i % 7 == 3) z = 32'd0;
      if (i % 11 == 5) begin x = 32'h8000_0000; z = 32'hFFFF_FFFF; end
      if (i % 5 == 1) z = z >> $urandom_range(0, 31);
      e  = ref_y(o, x, z);
      el = is_fast(o, x, z) ? 0 : 33;
      start(o, x, z, 5'(i));
      wait_out(lat);
      checks++; if (lat != el) begin errors++; $display("FAIL rnd%0d_latency op %0d got %0d exp %0d", i, o, lat, el); end
      checks++; if (y !== e) begin errors++; $display("FAIL rnd%0d_y op %0d a %h b %h got %h exp %h", i, o, x, z, y, e); end
      checks++; if (tag_out !== 5'(i)) begin errors++; $display("FAIL rnd%0d_tag got %0d exp %0d", i, tag_out, i); end
      pop();
    end
  endtask

  task automatic test_async_reset();
    int lat;
    start(3'd0, 32'd5, 32'd6, 5'd21);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin errors++; $display("FAIL arst_hs got ready %b valid %b exp 1 0", in_ready, out_valid); end
    checks++; if (y !== '0 || tag_out !== '0) begin errors++; $display("FAIL arst_y got %h/%0d exp 0/0", y, tag_out); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    start(3'd7, 32'd50, 32'd7, 5'd6);
    wait_out(lat);
    checks++; if (lat != 33 || y !== 32'd1) begin errors++; $display("FAIL arst_recover got %0d/%h exp 33/1", lat, y); end
    pop();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
